hdr_ins_arbiter: RTL and testbench

Round-robin scheduler that shares the single header-insert channel of the head_insert datapath between NUM_REQ header sources. It accepts one header beat (data, keep, byte count) from one requester and presents it on the downstream AXIS insert port. It then locks the grant until the inserter reports the end of the associated packet. Malformed headers are dropped and flagged.

---
 rtl/hdr_ins_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/hdr_ins_arbiter.sv | 163 ++++++++++++++++
 tb/tb_hdr_ins_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdr_ins_pkg.sv
// Shared definitions for the header-insert arbiter: FSM encoding and
// header validation helpers sized for the widest supported beat.
package hdr_ins_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PKT  = 2'd2
    } state_e;

    localparam int unsigned KEEP_MAX_WD = 64;
    localparam int unsigned CNT_MAX_WD  = 8;

    // Counts at or beyond the mask width wrap 0-1 to all-ones, so a full beat needs no special case.
    function automatic logic [KEEP_MAX_WD-1:0] keep_from_cnt(input logic [CNT_MAX_WD-1:0] cnt);
        return (KEEP_MAX_WD'(1) << cnt) - KEEP_MAX_WD'(1);
    endfunction

    function automatic logic hdr_well_formed(
        input logic [KEEP_MAX_WD-1:0] keep,
        input logic [CNT_MAX_WD-1:0]  cnt,
        input int unsigned            nbytes
    );
        return (cnt != '0) && (32'(cnt) <= nbytes) && (keep == keep_from_cnt(cnt));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo NUM_REQ; returns one-hot grant and its index.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_WD   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_WD-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_WD-1:0]   idx_o,
    output logic               any_o
);

    int unsigned        pos;
    logic [ID_WD-1:0]   j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        j     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = (32'(ptr_i) + k) % NUM_REQ;
            j   = ID_WD'(pos);
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/hdr_ins_arbiter.sv
// Shares the single header-insert channel between NUM_REQ sources; the grant
// stays locked from header accept until the inserter reports end of packet.
module hdr_ins_arbiter
    import hdr_ins_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int unsigned ID_WD        = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*DATA_WD-1:0]        req_data,
    input  logic [NUM_REQ*DATA_BYTE_WD-1:0]   req_keep,
    input  logic [NUM_REQ*(BYTE_CNT_WD+1)-1:0] req_byte_cnt,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              ins_valid_m,
    output logic [DATA_WD-1:0]                ins_data_m,
    output logic [DATA_BYTE_WD-1:0]           ins_keep_m,
    output logic [BYTE_CNT_WD:0]              ins_byte_insert_cnt,
    input  logic                              ins_ready_m,
    output logic [ID_WD-1:0]                  ins_grant_id,
    input  logic                              pkt_done,
    output logic                              busy,
    output logic                              proto_err
);

    localparam int unsigned CW = BYTE_CNT_WD + 1;

    state_e                  state_q, state_d;
    logic [ID_WD-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_WD-1:0]        gid_q, gid_d;
    logic                    err_q, err_d;
    logic [DATA_WD-1:0]      data_q;
    logic [DATA_BYTE_WD-1:0] keep_q;
    logic [CW-1:0]           cnt_q;

    logic [NUM_REQ-1:0]      gnt;
    logic [ID_WD-1:0]        g;
    logic                    any;
    logic                    accept_en;
    logic                    load;
    logic                    wf;
    logic [DATA_WD-1:0]      sel_data;
    logic [DATA_BYTE_WD-1:0] sel_keep;
    logic [CW-1:0]           sel_cnt;
    logic [KEEP_MAX_WD-1:0]  kmax;
    logic [CNT_MAX_WD-1:0]   cmax;

    function automatic logic [ID_WD-1:0] ptr_inc(input logic [ID_WD-1:0] p);
        if (32'(p) >= NUM_REQ - 1) return '0;
        return p + ID_WD'(1);
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_WD   (ID_WD)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (g),
        .any_o (any)
    );

    always_comb begin
        sel_data = req_data[int'(g)*DATA_WD +: DATA_WD];
        sel_keep = req_keep[int'(g)*DATA_BYTE_WD +: DATA_BYTE_WD];
        sel_cnt  = req_byte_cnt[int'(g)*CW +: CW];
        kmax     = '0;
        kmax[DATA_BYTE_WD-1:0] = sel_keep;
        cmax     = '0;
        cmax[CW-1:0] = sel_cnt;
        wf       = hdr_well_formed(kmax, cmax, DATA_BYTE_WD);
    end

    // Accepts are blocked during reset and in any pkt_done cycle.
    assign accept_en = rst_n && (state_q == S_IDLE) && !pkt_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            gid_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gid_q    <= gid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gid_d    = gid_q;
        err_d    = err_q;
        load     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pkt_done) begin
                    err_d = 1'b1;
                end else if (any) begin
                    if (wf) begin
                        load    = 1'b1;
                        gid_d   = g;
                        state_d = S_HDR;
                    end else begin
                        err_d    = 1'b1;
                        rr_ptr_d = ptr_inc(g);
                    end
                end
            end
            S_HDR: begin
                if (ins_ready_m) begin
                    if (pkt_done) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = ptr_inc(gid_q);
                    end else begin
                        state_d = S_PKT;
                    end
                end else if (pkt_done) begin
                    err_d = 1'b1;
                end
            end
            S_PKT: begin
                if (pkt_done) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = ptr_inc(gid_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = accept_en ? gnt : '0;
        ins_valid_m = (state_q == S_HDR);
        busy        = (state_q == S_HDR) || (state_q == S_PKT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            keep_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            data_q <= sel_data;
            keep_q <= sel_keep;
            cnt_q  <= sel_cnt;
        end
    end

    assign ins_data_m          = data_q;
    assign ins_keep_m          = keep_q;
    assign ins_byte_insert_cnt = cnt_q;
    assign ins_grant_id        = gid_q;
    assign proto_err           = err_q;

endmodule

// File: tb/tb_hdr_ins_arbiter.sv
// Directed bench for hdr_ins_arbiter with a scoreboard monitor checking
// accepts and header handshakes against queued expectations.
module tb_hdr_ins_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [15:0]  req_keep;
    logic [11:0]  req_byte_cnt;
    logic [3:0]   req_ready;
    logic         ins_valid_m;
    logic [31:0]  ins_data_m;
    logic [3:0]   ins_keep_m;
    logic [2:0]   ins_byte_insert_cnt;
    logic         ins_ready_m;
    logic [1:0]   ins_grant_id;
    logic         pkt_done;
    logic         busy;
    logic         proto_err;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic [2:0]  c;
        logic [1:0]  id;
    } hdr_t;

    hdr_t exp_hdr[$];
    int   exp_acc[$];
    int   vectors;
    int   miscompares;
    int   cyc;
    int   prev_cyc;
    int   mon_e;
    bit   have_prev;
    bit   spacing_en;
    hdr_t mon_h;

    hdr_ins_arbiter #(
        .NUM_REQ (4),
        .DATA_WD (32)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_valid           (req_valid),
        .req_data            (req_data),
        .req_keep            (req_keep),
        .req_byte_cnt        (req_byte_cnt),
        .req_ready           (req_ready),
        .ins_valid_m         (ins_valid_m),
        .ins_data_m          (ins_data_m),
        .ins_keep_m          (ins_keep_m),
        .ins_byte_insert_cnt (ins_byte_insert_cnt),
        .ins_ready_m         (ins_ready_m),
        .ins_grant_id        (ins_grant_id),
        .pkt_done            (pkt_done),
        .busy                (busy),
        .proto_err           (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int idx, input logic [31:0] d, input logic [3:0] k, input logic [2:0] c);
        req_data[idx*32 +: 32]    = d;
        req_keep[idx*4 +: 4]      = k;
        req_byte_cnt[idx*3 +: 3]  = c;
    endtask

    task automatic expect_pkt(input int idx, input logic [31:0] d, input logic [3:0] k, input logic [2:0] c);
        hdr_t h;
        h.d = d;
        h.k = k;
        h.c = c;
        h.id = 2'(idx);
        exp_acc.push_back(idx);
        exp_hdr.push_back(h);
    endtask

    task automatic wait_acc(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (req_ready != 4'b0) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: got no req_ready expected an accept within %0d cycles", lim);
    endtask

    // Called in an S_HDR cycle with ins_ready_m high; ends in the following S_IDLE cycle.
    task automatic do_pkt();
        @(posedge clk); #1 pkt_done = 1'b1;
        @(posedge clk); #1 pkt_done = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != 4'b0) begin
                if (exp_acc.size() == 0) begin
                    chk("unexpected_accept", 64'(req_ready), 64'h0);
                end else begin
                    mon_e = exp_acc.pop_front();
                    chk("accept_onehot", 64'(req_ready), 64'h1 << mon_e);
                end
                if (spacing_en && have_prev) chk("grant_spacing", 64'(cyc - prev_cyc), 64'd3);
                prev_cyc  = cyc;
                have_prev = spacing_en;
            end
            if (!spacing_en) have_prev = 1'b0;
            if (ins_valid_m && ins_ready_m) begin
                if (exp_hdr.size() == 0) begin
                    chk("unexpected_header", 64'(ins_data_m), 64'h0);
                end else begin
                    mon_h = exp_hdr.pop_front();
                    chk("hdr_data", 64'(ins_data_m), 64'(mon_h.d));
                    chk("hdr_keep", 64'(ins_keep_m), 64'(mon_h.k));
                    chk("hdr_cnt", 64'(ins_byte_insert_cnt), 64'(mon_h.c));
                    chk("hdr_id", 64'(ins_grant_id), 64'(mon_h.id));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors      = 0;
        miscompares  = 0;
        cyc          = 0;
        spacing_en   = 1'b0;
        rst_n        = 1'b0;
        req_valid    = 4'b0100;
        req_data     = '0;
        req_keep     = '0;
        req_byte_cnt = '0;
        ins_ready_m  = 1'b0;
        pkt_done     = 1'b0;

        #12;
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_ins_valid", 64'(ins_valid_m), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_proto_err", 64'(proto_err), 64'h0);
        chk("rst_grant_id", 64'(ins_grant_id), 64'h0);
        chk("rst_data", 64'(ins_data_m), 64'h0);
        req_valid = '0;
        @(posedge clk); #3 rst_n = 1'b1;

        // Fairness: all requesters valid, ptr starts at 0.
        for (int i = 0; i < 4; i++) set_req(i, 32'h1000_0000 + 32'(i), 4'hF, 3'd4);
        expect_pkt(0, 32'h1000_0000, 4'hF, 3'd4);
        expect_pkt(1, 32'h1000_0001, 4'hF, 3'd4);
        expect_pkt(2, 32'h1000_0002, 4'hF, 3'd4);
        expect_pkt(3, 32'h1000_0003, 4'hF, 3'd4);
        expect_pkt(0, 32'h1000_0000, 4'hF, 3'd4);
        ins_ready_m = 1'b1;
        spacing_en  = 1'b1;
        @(posedge clk); #1 req_valid = 4'hF;
        for (int n = 0; n < 5; n++) begin
            wait_acc(20);
            @(posedge clk); #1;
            if (n == 4) req_valid = 4'h0;
            do_pkt();
        end
        spacing_en = 1'b0;

        // Single requester, ptr now 1.
        ins_ready_m = 1'b0;
        set_req(1, 32'hA5A5_0001, 4'b0111, 3'd3);
        expect_pkt(1, 32'hA5A5_0001, 4'b0111, 3'd3);
        @(posedge clk); #1 req_valid = 4'b0010;
        wait_acc(20);
        @(posedge clk); #1 req_valid = 4'b0000;
        @(negedge clk);
        chk("single_valid", 64'(ins_valid_m), 64'h1);
        chk("single_grant", 64'(ins_grant_id), 64'h1);
        chk("single_busy", 64'(busy), 64'h1);
        @(posedge clk); #1 ins_ready_m = 1'b1;
        @(posedge clk); #1 ins_ready_m = 1'b0; pkt_done = 1'b1;
        @(posedge clk); #1 pkt_done = 1'b0;
        @(negedge clk);
        chk("single_busy_done", 64'(busy), 64'h0);
        chk("single_err", 64'(proto_err), 64'h0);

        // Backpressure on req 3 (ptr 2), req 0 waiting behind it.
        set_req(3, 32'h3C3C_0003, 4'b0011, 3'd2);
        set_req(0, 32'h0000_00AB, 4'b0001, 3'd1);
        expect_pkt(3, 32'h3C3C_0003, 4'b0011, 3'd2);
        expect_pkt(0, 32'h0000_00AB, 4'b0001, 3'd1);
        @(posedge clk); #1 req_valid = 4'b1000;
        wait_acc(20);
        @(posedge clk); #1 req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(ins_valid_m), 64'h1);
            chk("bp_data", 64'(ins_data_m), 64'h3C3C_0003);
            chk("bp_keep", 64'(ins_keep_m), 64'h3);
            chk("bp_req_ready", 64'(req_ready), 64'h0);
        end
        @(posedge clk); #1 ins_ready_m = 1'b1;
        do_pkt();
        wait_acc(20);
        @(posedge clk); #1 req_valid = 4'b0000;
        do_pkt();

        // Malformed headers from req 2 (ptr 1); inserter ready so a stray valid would surface.
        set_req(2, 32'hDEAD_0002, 4'b0101, 3'd2);
        exp_acc.push_back(2);
        @(posedge clk); #1 req_valid = 4'b0100;
        wait_acc(20);
        @(posedge clk); #1 req_valid = 4'b0000;
        @(negedge clk);
        chk("mal1_valid", 64'(ins_valid_m), 64'h0);
        chk("mal1_err", 64'(proto_err), 64'h1);
        chk("mal1_busy", 64'(busy), 64'h0);
        set_req(2, 32'hDEAD_0012, 4'b0000, 3'd0);
        exp_acc.push_back(2);
        @(posedge clk); #1 req_valid = 4'b0100;
        wait_acc(20);
        @(posedge clk); #1 req_valid = 4'b0000;
        @(negedge clk);
        chk("mal2_valid", 64'(ins_valid_m), 64'h0);
        chk("mal2_err", 64'(proto_err), 64'h1);
        set_req(1, 32'h1111_0001, 4'hF, 3'd4);
        set_req(3, 32'h3333_0003, 4'b0001, 3'd1);
        expect_pkt(3, 32'h3333_0003, 4'b0001, 3'd1);
        expect_pkt(1, 32'h1111_0001, 4'hF, 3'd4);
        @(posedge clk); #1 req_valid = 4'b1010;
        wait_acc(20);
        @(posedge clk); #1 req_valid = 4'b0010;
        do_pkt();
        wait_acc(20);
        @(posedge clk); #1 req_valid = 4'b0000;
        do_pkt();
        @(negedge clk);
        chk("err_sticky", 64'(proto_err), 64'h1);

        // Zero-payload packet after a fresh reset.
        ins_ready_m = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        #2 chk("err_cleared", 64'(proto_err), 64'h0);
        @(posedge clk); #2 rst_n = 1'b1;
        set_req(0, 32'h0A0A_0000, 4'b0011, 3'd2);
        expect_pkt(0, 32'h0A0A_0000, 4'b0011, 3'd2);
        ins_ready_m = 1'b1;
        @(posedge clk); #1 req_valid = 4'b0001;
        wait_acc(20);
        @(posedge clk); #1 req_valid = 4'b0000; pkt_done = 1'b1;
        @(posedge clk); #1 pkt_done = 1'b0;
        @(negedge clk);
        chk("zp_busy", 64'(busy), 64'h0);
        chk("zp_valid", 64'(ins_valid_m), 64'h0);
        chk("zp_err", 64'(proto_err), 64'h0);
        @(posedge clk); #1 pkt_done = 1'b1;
        @(posedge clk); #1 pkt_done = 1'b0;
        @(negedge clk);
        chk("stray_err", 64'(proto_err), 64'h1);

        // Reset while req 2 owns a packet (ptr 1).
        set_req(2, 32'h2222_2222, 4'b0111, 3'd3);
        expect_pkt(2, 32'h2222_2222, 4'b0111, 3'd3);
        @(posedge clk); #1 req_valid = 4'b0100;
        wait_acc(20);
        @(posedge clk); #1 req_valid = 4'b0000;
        @(posedge clk); #2;
        chk("mid_busy", 64'(busy), 64'h1);
        chk("mid_grant", 64'(ins_grant_id), 64'h2);
        req_valid = 4'b0010;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(ins_valid_m), 64'h0);
        chk("async_busy", 64'(busy), 64'h0);
        chk("async_grant", 64'(ins_grant_id), 64'h0);
        chk("async_data", 64'(ins_data_m), 64'h0);
        chk("async_keep", 64'(ins_keep_m), 64'h0);
        chk("async_cnt", 64'(ins_byte_insert_cnt), 64'h0);
        chk("async_err", 64'(proto_err), 64'h0);
        chk("async_req_ready", 64'(req_ready), 64'h0);
        @(posedge clk); #1 req_valid = 4'b0000;
        set_req(0, 32'h0000_C0DE, 4'hF, 3'd4);
        set_req(3, 32'h0000_BEEF, 4'b0011, 3'd2);
        expect_pkt(0, 32'h0000_C0DE, 4'hF, 3'd4);
        expect_pkt(3, 32'h0000_BEEF, 4'b0011, 3'd2);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1 req_valid = 4'b1001;
        wait_acc(20);
        @(posedge clk); #1 req_valid = 4'b1000;
        do_pkt();
        wait_acc(20);
        @(posedge clk); #1 req_valid = 4'b0000;
        do_pkt();

        repeat (3) @(negedge clk);
        chk("acc_queue_empty", 64'(exp_acc.size()), 64'h0);
        chk("hdr_queue_empty", 64'(exp_hdr.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
